// File: rtl/mem_ports_pkg.sv
// Shared types and the word-merge helper for the parameterised memory-port block.
package mem_ports_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    READY
  } init_state_e;

  // The merge helper works on the widest supported word so one function serves every instance.
  localparam int MAX_DW    = 64;
  localparam int MAX_LANES = 64;

  typedef logic [MAX_DW-1:0]    word_t;
  typedef logic [MAX_LANES-1:0] lanes_t;

  // Applies a lane-masked write, then an optional part-select write clipped at bit dw-1.
  // The caller gates mask/part_en so that a masked write always wins over a part write.
  function automatic word_t merge_word(word_t old_word, word_t data, lanes_t mask,
                                       logic part_en, int base, word_t part_data,
                                       int dw, int lw, int pw);
    word_t dw_bits;
    word_t lane_one;
    word_t part_one;
    word_t wmask;
    word_t pmask;
    word_t res;
    dw_bits  = (word_t'(1) << dw) - word_t'(1);
    lane_one = (word_t'(1) << lw) - word_t'(1);
    part_one = (word_t'(1) << pw) - word_t'(1);
    wmask    = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (mask[i]) wmask = wmask | (lane_one << (i * lw));
    end
    wmask = wmask & dw_bits;
    res   = (old_word & ~wmask) | (data & wmask);
    // Bits shifted past dw-1 fall outside dw_bits, which gives the no-wrap clipping.
    pmask = (part_one << base) & dw_bits;
    if (part_en) res = (res & ~pmask) | ((part_data << base) & pmask);
    return res;
  endfunction

endpackage

// File: rtl/mem_ports_param_if.sv
// Write/read bus of the memory-port block; master drives requests, slave returns data.
interface mem_ports_param_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int NR = 2,
  parameter int LW = 4,
  parameter int PW = 4,
  parameter int BW = (DW > 1) ? $clog2(DW) : 1
);
  logic             init_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [DW/LW-1:0] wr_mask;
  logic             wr_part_en;
  logic [BW-1:0]    wr_base;
  logic [PW-1:0]    wr_part_data;
  logic             wr_conflict;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, wr_part_en, wr_base, wr_part_data,
           rd_en, rd_addr,
    input  init_busy, wr_conflict, rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, wr_part_en, wr_base, wr_part_data,
           rd_en, rd_addr,
    output init_busy, wr_conflict, rd_data, rd_valid
  );
endinterface

// File: rtl/mem_rd_port.sv
// One registered read port: read-during-write select, enable/hold register, optional second stage.
module mem_rd_port
  import mem_ports_pkg::*;
#(
  parameter int DW       = 8,
  parameter int RDW_MODE = 0,
  parameter int RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] old_word,
  input  logic [DW-1:0] new_word,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  logic [DW-1:0] sel_word;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic          v1;
  logic          v2;

  assign sel_word = (RDW_MODE == int'(RDW_WRITE_FIRST)) ? new_word : old_word;

  // Capture on enable, hold otherwise; the second stage only advances on valid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= en;
      if (en) d1 <= sel_word;
      v2 <= v1;
      if (v1) d2 <= d1;
    end
  end

  assign rd_data  = (RD_LAT == 2) ? d2 : d1;
  assign rd_valid = (RD_LAT == 2) ? v2 : v1;

endmodule

// File: rtl/mem_ports_param.sv
// 1-write / NR-read synchronous memory with masked and part-select writes and a zeroing sweep.
module mem_ports_param
  import mem_ports_pkg::*;
#(
  parameter int DW            = 8,
  parameter int DEPTH         = 16,
  parameter int AW            = $clog2(DEPTH),
  parameter int NR            = 2,
  parameter int LW            = 4,
  parameter int PW            = 4,
  parameter int RDW_MODE      = 0,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input logic             clk,
  input logic             rst,
  mem_ports_param_if.slave bus
);

  localparam int            NL      = DW / LW;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  init_state_e   state;
  logic [AW-1:0] init_cnt;
  logic          accept;
  logic          wr_in_range;
  logic [NL-1:0] mask_g;
  logic          part_g;
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] mem [DEPTH];
  logic [NR*DW-1:0] rd_data_w;
  logic [NR-1:0]    rd_valid_w;

  // Requests are only honoured once the sweep is done (or immediately when there is no sweep).
  assign accept = !rst && ((state == READY) || (INIT_ON_RESET == 0));

  // Masked write has priority: the part write is suppressed whenever wr_en is high.
  assign mask_g = bus.wr_en ? bus.wr_mask : '0;
  assign part_g = bus.wr_part_en & ~bus.wr_en;

  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_W;
  assign wr_old      = wr_in_range ? mem[bus.wr_addr] : '0;
  assign wr_word     = DW'(merge_word(word_t'(wr_old), word_t'(bus.wr_data), lanes_t'(mask_g),
                                      part_g, int'(bus.wr_base), word_t'(bus.wr_part_data),
                                      DW, LW, PW));

  // Init sequencer plus the registered conflict flag.
  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      init_cnt        <= '0;
      bus.init_busy   <= 1'b0;
      bus.wr_conflict <= 1'b0;
    end else begin
      bus.wr_conflict <= accept && bus.wr_en && bus.wr_part_en;
      case (state)
        IDLE: begin
          init_cnt <= '0;
          if (INIT_ON_RESET != 0) begin
            state         <= INIT;
            bus.init_busy <= 1'b1;
          end else begin
            state <= READY;
          end
        end
        INIT: begin
          if (init_cnt == AW'(DEPTH - 1)) begin
            state         <= READY;
            bus.init_busy <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        READY:   state <= READY;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: sweep writes zero one word per cycle, otherwise the merged write word lands.
  // NOTE: the array is deliberately not reset; clearing it is the job of the init sweep.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else if (accept && wr_in_range && (bus.wr_en || bus.wr_part_en)) begin
      mem[bus.wr_addr] <= wr_word;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          in_range;
    logic          bypass;
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;

    assign ra       = bus.rd_addr[p*AW +: AW];
    assign in_range = {1'b0, ra} < DEPTH_W;
    assign old_w    = in_range ? mem[ra] : '0;
    // Post-write view of this port's word; equals old_w unless the write hits the same address.
    assign bypass   = in_range && (ra == bus.wr_addr) && accept;
    assign new_w    = DW'(merge_word(word_t'(old_w), word_t'(bus.wr_data),
                                     lanes_t'(bypass ? mask_g : '0), part_g & bypass,
                                     int'(bus.wr_base), word_t'(bus.wr_part_data),
                                     DW, LW, PW));

    mem_rd_port #(
      .DW       (DW),
      .RDW_MODE (RDW_MODE),
      .RD_LAT   (RD_LAT)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .en       (accept && bus.rd_en[p]),
      .old_word (old_w),
      .new_word (new_w),
      .rd_data  (rd_data_w[p*DW +: DW]),
      .rd_valid (rd_valid_w[p])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_valid = rd_valid_w;

endmodule

// File: tb/tb_mem_ports_param.sv
// Two instances share one stimulus stream: A = depth 16, read-first, latency 1;
// B = depth 12, write-first, latency 2. A scoreboard per read port holds expected words.
module tb_mem_ports_param;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] wr_mask = '0;
  logic       wr_part_en = 1'b0;
  logic [2:0] wr_base = '0;
  logic [3:0] wr_part_data = '0;
  logic [1:0] rd_en = '0;
  logic [7:0] rd_addr = '0;

  int   cyc = 0;
  logic rst_q = 1'b1;
  bit   accepting = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  exp_t       sb [4][$];
  int         cq [2][$];
  logic [7:0] model [2][16];
  logic [7:0] last [4];
  int         depth_c [2] = '{16, 12};
  int         lat_c   [2] = '{1, 2};
  int         rdw_c   [2] = '{0, 1};

  mem_ports_param_if #(.DW(8), .AW(4), .NR(2), .LW(4), .PW(4)) bus_a ();
  mem_ports_param_if #(.DW(8), .AW(4), .NR(2), .LW(4), .PW(4)) bus_b ();

  assign bus_a.wr_en = wr_en;           assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr;       assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data;       assign bus_b.wr_data = wr_data;
  assign bus_a.wr_mask = wr_mask;       assign bus_b.wr_mask = wr_mask;
  assign bus_a.wr_part_en = wr_part_en; assign bus_b.wr_part_en = wr_part_en;
  assign bus_a.wr_base = wr_base;       assign bus_b.wr_base = wr_base;
  assign bus_a.wr_part_data = wr_part_data; assign bus_b.wr_part_data = wr_part_data;
  assign bus_a.rd_en = rd_en;           assign bus_b.rd_en = rd_en;
  assign bus_a.rd_addr = rd_addr;       assign bus_b.rd_addr = rd_addr;

  mem_ports_param #(
    .DW(8), .DEPTH(16), .NR(2), .LW(4), .PW(4), .RDW_MODE(0), .RD_LAT(1), .INIT_ON_RESET(1)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_ports_param #(
    .DW(8), .DEPTH(12), .NR(2), .LW(4), .PW(4), .RDW_MODE(1), .RD_LAT(2), .INIT_ON_RESET(1)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference merge, bit by bit.
  function automatic logic [7:0] tb_merge(input logic [7:0] old, input logic we,
                                          input logic [7:0] wd, input logic [1:0] wm,
                                          input logic pe, input logic [2:0] wb,
                                          input logic [3:0] wp);
    logic [7:0] r;
    r = old;
    if (we) begin
      for (int b = 0; b < 8; b++) if (wm[b / 4]) r[b] = wd[b];
    end else if (pe) begin
      for (int j = 0; j < 4; j++) if (int'(wb) + j < 8) r[int'(wb) + j] = wp[j];
    end
    return r;
  endfunction

  // Output monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        logic       v;
        logic [7:0] d;
        bit         expv;
        exp_t       e;
        string      nm;
        nm = $sformatf("%s%0d", (k < 2) ? "a" : "b", k % 2);
        v  = (k < 2) ? bus_a.rd_valid[k % 2] : bus_b.rd_valid[k % 2];
        d  = (k < 2) ? bus_a.rd_data[(k % 2) * 8 +: 8] : bus_b.rd_data[(k % 2) * 8 +: 8];
        if (rst_q) begin
          sb[k].delete();
          last[k] = '0;
          check({"rst_valid_", nm}, 32'(v), 32'(0));
          check({"rst_data_", nm}, 32'(d), 32'(0));
        end else begin
          expv = (sb[k].size() > 0) && (sb[k][0].due == cyc);
          check({"rd_valid_", nm}, 32'(v), 32'(expv));
          if (expv) begin
            e = sb[k].pop_front();
            check({"rd_data_", nm}, 32'(d), 32'(e.data));
            last[k] = e.data;
          end else begin
            check({"rd_hold_", nm}, 32'(d), 32'(last[k]));
          end
        end
      end
      for (int j = 0; j < 2; j++) begin
        bit   expc;
        logic wc;
        wc   = (j == 0) ? bus_a.wr_conflict : bus_b.wr_conflict;
        expc = (cq[j].size() > 0) && (cq[j][0] == cyc);
        if (expc) void'(cq[j].pop_front());
        if (rst_q) cq[j].delete();
        check($sformatf("conflict_%s", (j == 0) ? "a" : "b"), 32'(wc), 32'(expc && !rst_q));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    wr_part_en = 1'b0; wr_base = '0; wr_part_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  // Drive one cycle of requests and record what each instance must return.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [1:0] wm, input logic pe, input logic [2:0] wb,
                       input logic [3:0] wp, input logic [1:0] re,
                       input logic [3:0] ra0, input logic [3:0] ra1);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    wr_part_en = pe; wr_base = wb; wr_part_data = wp;
    rd_en = re; rd_addr = {ra1, ra0};
    if (accepting) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (re[p]) begin
            logic [3:0] ra;
            logic [7:0] old_w;
            logic [7:0] new_w;
            exp_t       e;
            ra    = (p == 0) ? ra0 : ra1;
            old_w = (int'(ra) < depth_c[d]) ? model[d][ra] : 8'h00;
            new_w = (int'(ra) < depth_c[d] && ra == wa) ?
                    tb_merge(old_w, we, wd, wm, pe, wb, wp) : old_w;
            e.due  = cyc + lat_c[d];
            e.data = (rdw_c[d] != 0) ? new_w : old_w;
            sb[d * 2 + p].push_back(e);
          end
        end
        if (we && pe) cq[d].push_back(cyc + 1);
        if (int'(wa) < depth_c[d]) model[d][wa] = tb_merge(model[d][wa], we, wd, wm, pe, wb, wp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0);
  endtask

  // Reset, optionally re-assert reset mid-sweep, then measure the sweep length of both instances.
  task automatic reset_and_init(input bit junk, input int restart_at);
    int na;
    int nb;
    accepting = 1'b0;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("busy_in_rst_a", 32'(bus_a.init_busy), 32'(0));
      check("busy_in_rst_b", 32'(bus_b.init_busy), 32'(0));
      rst = 1'b0;
    end
    if (junk) begin
      wr_en = 1'b1; wr_part_en = 1'b1; wr_mask = 2'b11; wr_data = 8'hFF;
      wr_addr = 4'd0; wr_part_data = 4'hF; rd_en = 2'b11; rd_addr = 8'h50;
    end
    na = 0;
    nb = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus_a.init_busy) na++;
      if (bus_b.init_busy) nb++;
      if (n == 4) clear_inputs();
      if (na > 0 && !bus_a.init_busy) break;
    end
    check("init_busy_cycles_a", 32'(na), 32'(16));
    check("init_busy_cycles_b", 32'(nb), 32'(12));
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
    accepting = 1'b1;
  endtask

  initial begin
    reset_and_init(1'b1, 0);

    // Every address reads zero after the sweep; B returns zero for 12..15 as well.
    for (int i = 0; i < 16; i++) drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'(i), 4'(15 - i));

    // Masked writes: FF, then low lane AB -> FB, then an all-zero mask changes nothing.
    drive(1, 4'd3, 8'hFF, 2'b11, 0, 0, 4'h0, 2'b00, 0, 0);
    drive(1, 4'd3, 8'hAB, 2'b01, 0, 0, 4'h0, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b01, 4'd3, 0);
    drive(1, 4'd3, 8'h55, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd3, 4'd3);
    // Out-of-range on B: write dropped, read gives 0 with valid.
    drive(1, 4'd13, 8'h77, 2'b11, 0, 0, 4'h0, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd13, 4'd12);

    // Part-select writes: base 6 clips to C0; base 2 lands fully as 28.
    drive(0, 4'd7, 8'h00, 2'b00, 1, 3'd6, 4'hF, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd7, 4'd6);
    drive(0, 4'd8, 8'h00, 2'b00, 1, 3'd2, 4'hA, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd8, 4'd7);

    // Read-during-write on address 5 from both ports.
    drive(1, 4'd5, 8'h11, 2'b11, 0, 0, 4'h0, 2'b00, 0, 0);
    drive(1, 4'd5, 8'h22, 2'b11, 0, 0, 4'h0, 2'b11, 4'd5, 4'd5);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd5, 4'd5);
    drive(0, 4'd5, 8'h00, 2'b00, 1, 3'd6, 4'hF, 2'b11, 4'd5, 4'd5);
    drive(1, 4'd5, 8'h90, 2'b10, 0, 0, 4'h0, 2'b11, 4'd5, 4'd5);

    // Conflicts: masked data wins; an all-zero mask still discards the part write.
    drive(1, 4'd9, 8'h3C, 2'b11, 1, 3'd0, 4'hF, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd9, 4'd9);
    drive(1, 4'd10, 8'h00, 2'b00, 1, 3'd0, 4'hF, 2'b00, 0, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b01, 4'd10, 0);
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b10, 0, 4'd9);
    idle(4);

    // Random mix of writes, conflicts and reads.
    for (int n = 0; n < 80; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
            2'($urandom), 1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
            2'($urandom), 4'($urandom), 4'($urandom));
    end
    drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'd9, 4'd3);
    idle(3);

    // Reset re-asserted mid-sweep: sweep restarts and clears everything.
    reset_and_init(1'b0, 7);
    for (int i = 0; i < 16; i++) drive(0, 0, 8'h00, 2'b00, 0, 0, 4'h0, 2'b11, 4'(i), 4'(15 - i));
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
